// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: core-side push handshake plus transmitter data/ok/busy link
interface uart_tx_queue_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [7:0] tx_data;
  logic tx_ok;
  logic tx_busy;
  modport master(output in_data, in_valid, tx_busy, input in_ready, tx_data, tx_ok);
  modport slave(input in_data, in_valid, tx_busy, output in_ready, tx_data, tx_ok);
endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a UART transmitter, one tx_ok pulse per stored byte
module uart_tx_queue #(
  parameter int DEPTH_LOG2 = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  uart_tx_queue_if.slave bus,
  output logic [DEPTH_LOG2:0] count,
  output logic empty,
  output logic overflow,
  output logic ack_error
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, ACK, DRAIN} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic tx_ok_q, tx_ok_d, overflow_q, overflow_d, ack_error_q, ack_error_d;
  logic push, pop;
  assign bus.in_ready = count_q < (DEPTH_LOG2+1)'(DEPTH);
  assign bus.tx_data = tx_data_q;
  assign bus.tx_ok = tx_ok_q;
  assign count = count_q;
  assign empty = count_q == '0;
  assign overflow = overflow_q;
  assign ack_error = ack_error_q;
  // Issue is held off while the transmitter still reports busy.
  always_comb begin
    push = bus.in_valid && bus.in_ready;
    pop = state_q == IDLE && count_q != '0 && !bus.tx_busy;
    wr_ptr_d = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    count_d = count_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    overflow_d = overflow_q || (bus.in_valid && !bus.in_ready);
    tx_data_d = pop ? mem_q[rd_ptr_q] : tx_data_q;
    tx_ok_d = pop;
    ack_error_d = ack_error_q;
    timer_d = timer_q;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        state_d = pop ? ISSUE : IDLE;
        timer_d = pop ? '0 : timer_q;
      end
      ISSUE: state_d = ACK;
      ACK: begin
        if (bus.tx_busy) state_d = DRAIN;
        else if (int'(timer_q) + 1 >= ACK_TIMEOUT) begin
          ack_error_d = 1'b1;
          state_d = IDLE;
        end else timer_d = timer_q + TW'(1);
      end
      default: state_d = bus.tx_busy ? DRAIN : IDLE;
    endcase
  end
  always_ff @(posedge clk) if (push) mem_q[wr_ptr_q] <= bus.in_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      timer_q <= '0;
      tx_data_q <= '0;
      tx_ok_q <= 1'b0;
      overflow_q <= 1'b0;
      ack_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      timer_q <= timer_d;
      tx_data_q <= tx_data_d;
      tx_ok_q <= tx_ok_d;
      overflow_q <= overflow_d;
      ack_error_q <= ack_error_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: random and directed traffic against a queue-based transfer model
module tb_uart_tx_queue;
  localparam int DL = 2;
  localparam int AT = 8;
  localparam int DEPTH = 1 << DL;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  uart_tx_queue_if bus();
  logic [DL:0] count;
  logic empty, overflow, ack_error;
  uart_tx_queue #(.DEPTH_LOG2(DL), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .count(count),
    .empty(empty), .overflow(overflow), .ack_error(ack_error)
  );
  int checks = 0, failures = 0;
  logic [7:0] q[$];
  int since = -1;
  bit seen_busy = 0, m_ovf = 0, m_ackerr = 0, m_ok = 0;
  logic [7:0] m_data = 8'h00;
  int busy_len = 40, cnt = 0, cyc = 0, last_ok = -1, n_ok = 0, snap;
  bit force_busy = 0, no_resp = 0, gap_chk = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(bit v, logic [7:0] d);
    bit busy_now, ok_pre, can_push;
    bus.in_valid = v;
    bus.in_data = d;
    busy_now = bus.tx_busy;
    ok_pre = bus.tx_ok;
    if (reset) begin
      q.delete();
      since = -1; seen_busy = 0; m_ovf = 0; m_ackerr = 0; m_ok = 0; m_data = 8'h00;
    end else begin
      can_push = q.size() < DEPTH;
      m_ok = 0;
      if (v && !can_push) m_ovf = 1;
      if (since < 0) begin
        if (q.size() > 0 && !busy_now) begin
          m_data = q.pop_front(); m_ok = 1; since = 0; seen_busy = 0;
        end
      end else begin
        since++;
        if (seen_busy) begin
          if (!busy_now) since = -1;
        end else if (since >= 2 && busy_now) seen_busy = 1;
        else if (since == AT + 1) begin
          m_ackerr = 1; since = -1;
        end
      end
      if (v && can_push) q.push_back(d);
    end
    @(posedge clk); #1;
    cyc++;
    if (reset) cnt = 0;
    else if (ok_pre && !no_resp) cnt = busy_len;
    else if (cnt > 0) cnt--;
    bus.tx_busy = force_busy || cnt > 0;
    check("tx_ok", bus.tx_ok, m_ok);
    check("tx_data", bus.tx_data, m_data);
    check("count", count, q.size());
    check("empty", empty, q.size() == 0);
    check("in_ready", bus.in_ready, q.size() < DEPTH);
    check("overflow", overflow, m_ovf);
    check("ack_error", ack_error, m_ackerr);
    if (bus.tx_ok) begin
      n_ok++;
      if (!force_busy) check("busy_at_ok", bus.tx_busy, 0);
      if (gap_chk && last_ok >= 0) check("ok_gap_ge_43", cyc - last_ok >= busy_len + 3, 1);
      last_ok = cyc;
    end
  endtask
  task automatic do_reset();
    force_busy = 0;
    reset = 1'b1;
    tick(0, 8'h00);
    reset = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.tx_busy = 1'b0;
    do_reset();
    check("rst_count", count, 0);
    check("rst_ready", bus.in_ready, 1);
    tick(1, 8'hA5);
    check("a5_count", count, 1);
    tick(0, 8'h00);
    check("a5_ok", bus.tx_ok, 1);
    check("a5_data", bus.tx_data, 8'hA5);
    repeat (60) tick(0, 8'h00);
    snap = n_ok; gap_chk = 1; last_ok = -1;
    for (int i = 1; i <= 5; i++) tick(1, 8'(i));
    repeat (260) tick(0, 8'h00);
    gap_chk = 0;
    check("burst_pulses", n_ok - snap, 5);
    busy_len = 5; force_busy = 1; bus.tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) tick(1, 8'h10 + 8'(i));
    check("full_count", count, 4);
    check("full_ovf", overflow, 1);
    force_busy = 0; bus.tx_busy = cnt > 0;
    snap = n_ok;
    repeat (60) tick(0, 8'h00);
    check("drain_pulses", n_ok - snap, 4);
    for (int i = 0; i < 4; i++) tick(1, 8'h20 + 8'(i));
    repeat (60) tick(0, 8'h00);
    check("ovf_sticky", overflow, 1);
    do_reset();
    force_busy = 1; bus.tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) tick(1, 8'h30 + 8'(i));
    force_busy = 0; bus.tx_busy = 1'b0;
    tick(1, 8'h77);
    check("popfull_count", count, 3);
    check("popfull_ovf", overflow, 1);
    repeat (60) tick(0, 8'h00);
    do_reset();
    no_resp = 1;
    tick(1, 8'h3C);
    repeat (AT + 4) tick(0, 8'h00);
    check("timeout_err", ack_error, 1);
    no_resp = 0; snap = n_ok;
    tick(1, 8'h5A);
    repeat (30) tick(0, 8'h00);
    check("after_timeout_pulses", n_ok - snap, 1);
    do_reset();
    busy_len = 40;
    for (int i = 0; i < 4; i++) tick(1, 8'h40 + 8'(i));
    repeat (8) tick(0, 8'h00);
    check("drain_count3", count, 3);
    do_reset();
    check("rst_mid_count", count, 0);
    check("rst_mid_ok", bus.tx_ok, 0);
    snap = n_ok;
    repeat (50) tick(0, 8'h00);
    check("rst_mid_pulses", n_ok - snap, 0);
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        busy_len = $urandom_range(0, 12);
        no_resp = $urandom_range(0, 5) == 0;
      end
      if ($urandom_range(0, 40) == 0) begin
        force_busy = !force_busy;
        bus.tx_busy = force_busy || cnt > 0;
      end
      if ($urandom_range(0, 700) == 0) do_reset();
      else tick($urandom_range(0, 2) != 0, 8'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
